// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timebase: FSM state codes, BCD digit
// limits and prescaler sizing helpers.
package stopwatch_pkg;

  // RUN shares its code with the control FSM's start state.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RUN   = 4'd3,
    PAUSE = 4'd4,
    DONE  = 4'd5
  } state_t;

  localparam int BCD_MAX_UNITS = 9;
  localparam int BCD_MAX_TENS  = 5;

  function automatic int calcDiv(input int clkHz, input int tickHz);
    return clkHz / tickHz;
  endfunction

  function automatic int calcCntW(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the cascaded time counter; wraps at MAX going up and
// at 0 going down, flagging carry/borrow on the stepping edge.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MAX = BCD_MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       dir,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] loadVal,
  output logic [3:0] value,
  output logic       carry
);

  localparam logic [3:0] TOP = 4'(MAX);

  assign carry = step && (dir ? (value == 4'd0) : (value == TOP));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= 4'd0;
    end else if (load) begin
      value <= loadVal;
    end else if (step) begin
      if (dir) value <= (value == 4'd0) ? TOP : value - 4'd1;
      else     value <= (value == TOP) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch/countdown core: prescaler-derived tick driving an MM:SS.mmm BCD
// counter, with pause/resume, lap freeze and countdown expiry.
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        dir_down,
  input  logic        load,
  input  logic [7:0]  preset_min,
  input  logic [7:0]  preset_sec,
  output logic        tick,
  output logic        running,
  output logic        expired,
  output logic        lap_active,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic [11:0] ms_bcd
);

  localparam int DIV   = calcDiv(CLK_HZ, TICK_HZ);
  localparam int CNT_W = calcCntW(DIV);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DIV - 1);

  // Out-of-range digits collapse the whole field to 59.
  function automatic logic [7:0] clampBcd59(input logic [7:0] v);
    if (v[7:4] > 4'(BCD_MAX_TENS) || v[3:0] > 4'(BCD_MAX_UNITS)) return 8'h59;
    return v;
  endfunction

  state_t           state, stateNext;
  logic [CNT_W-1:0] preCnt;
  logic             dirLatch;
  logic [7:0]       snapMin, snapSec;
  logic [11:0]      snapMs;
  logic [7:0]       liveMin, liveSec;
  logic [11:0]      liveMs;
  logic [7:0]       presetMinC, presetSecC;

  logic startEff, isRun, preLast, stepMs, loadEff;
  logic allZero, atOneMs, hitZero, zeroStart, lapToggle;

  assign presetMinC = clampBcd59(preset_min);
  assign presetSecC = clampBcd59(preset_sec);

  assign startEff  = start && !stop && !clear;
  assign isRun     = (state == RUN);
  assign preLast   = (preCnt == PRE_LAST);
  assign stepMs    = isRun && !clear && !stop && preLast;
  assign loadEff   = load && (state == IDLE) && !start && !clear;
  assign allZero   = ({liveMin, liveSec, liveMs} == 28'd0);
  assign atOneMs   = ({liveMin, liveSec, liveMs} == 28'd1);
  assign hitZero   = stepMs && dirLatch && atOneMs;
  assign zeroStart = (state == IDLE) && startEff && dir_down && allZero;
  assign lapToggle = isRun && lap && !clear;
  assign running   = isRun;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (clear) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (startEff) stateNext = zeroStart ? DONE : RUN;
        RUN: begin
          if (stop)         stateNext = PAUSE;
          else if (hitZero) stateNext = DONE;
        end
        PAUSE:   if (startEff) stateNext = RUN;
        DONE:    stateNext = DONE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Prescaler holds through PAUSE so a resume keeps the partial tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      preCnt     <= '0;
      dirLatch   <= 1'b0;
      tick       <= 1'b0;
      expired    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      tick    <= stepMs;
      expired <= hitZero || zeroStart;
      if (clear)                 preCnt <= '0;
      else if (isRun && !stop)   preCnt <= preLast ? '0 : preCnt + CNT_W'(1);
      if (clear)                           dirLatch <= 1'b0;
      else if (state == IDLE && startEff)  dirLatch <= dir_down;
      if (clear)          lap_active <= 1'b0;
      else if (lapToggle) lap_active <= !lap_active;
    end
  end

  always_ff @(posedge clk) begin
    if (lapToggle && !lap_active) begin
      snapMin <= liveMin;
      snapSec <= liveSec;
      snapMs  <= liveMs;
    end
  end

  assign min_bcd = lap_active ? snapMin : liveMin;
  assign sec_bcd = lap_active ? snapSec : liveSec;
  assign ms_bcd  = lap_active ? snapMs  : liveMs;

  logic cMs0, cMs1, cMs2, cSec0, cSec1, cMin0, carryUnused;

  bcd_digit #(.MAX(BCD_MAX_UNITS)) uMs0 (
    .clk(clk), .rst(rst), .step(stepMs), .dir(dirLatch), .clear(clear),
    .load(loadEff), .loadVal(4'd0), .value(liveMs[3:0]), .carry(cMs0));
  bcd_digit #(.MAX(BCD_MAX_UNITS)) uMs1 (
    .clk(clk), .rst(rst), .step(cMs0), .dir(dirLatch), .clear(clear),
    .load(loadEff), .loadVal(4'd0), .value(liveMs[7:4]), .carry(cMs1));
  bcd_digit #(.MAX(BCD_MAX_UNITS)) uMs2 (
    .clk(clk), .rst(rst), .step(cMs1), .dir(dirLatch), .clear(clear),
    .load(loadEff), .loadVal(4'd0), .value(liveMs[11:8]), .carry(cMs2));
  bcd_digit #(.MAX(BCD_MAX_UNITS)) uSec0 (
    .clk(clk), .rst(rst), .step(cMs2), .dir(dirLatch), .clear(clear),
    .load(loadEff), .loadVal(presetSecC[3:0]), .value(liveSec[3:0]), .carry(cSec0));
  bcd_digit #(.MAX(BCD_MAX_TENS)) uSec1 (
    .clk(clk), .rst(rst), .step(cSec0), .dir(dirLatch), .clear(clear),
    .load(loadEff), .loadVal(presetSecC[7:4]), .value(liveSec[7:4]), .carry(cSec1));
  bcd_digit #(.MAX(BCD_MAX_UNITS)) uMin0 (
    .clk(clk), .rst(rst), .step(cSec1), .dir(dirLatch), .clear(clear),
    .load(loadEff), .loadVal(presetMinC[3:0]), .value(liveMin[3:0]), .carry(cMin0));
  bcd_digit #(.MAX(BCD_MAX_TENS)) uMin1 (
    .clk(clk), .rst(rst), .step(cMin0), .dir(dirLatch), .clear(clear),
    .load(loadEff), .loadVal(presetMinC[7:4]), .value(liveMin[7:4]), .carry(carryUnused));

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
module tb_stopwatch_timebase;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic        dir_down = 1'b0, load = 1'b0;
  logic [7:0]  preset_min = 8'h00, preset_sec = 8'h00;
  logic        tick, running, expired, lap_active;
  logic [7:0]  min_bcd, sec_bcd;
  logic [11:0] ms_bcd;
  logic [27:0] disp;

  int checks = 0;
  int failures = 0;
  int tickCnt, expCnt;

  stopwatch_timebase #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .dir_down(dir_down), .load(load), .preset_min(preset_min), .preset_sec(preset_sec),
    .tick(tick), .running(running), .expired(expired), .lap_active(lap_active),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .ms_bcd(ms_bcd));

  assign disp = {min_bcd, sec_bcd, ms_bcd};

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic doEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      doEdge();
      if (tick) tickCnt++;
      if (expired) expCnt++;
    end
  endtask

  task automatic pulseClear();
    clear = 1'b1; doEdge(); clear = 1'b0;
    tickCnt = 0; expCnt = 0;
  endtask

  task automatic pulseStart(input logic down);
    dir_down = down; start = 1'b1; doEdge(); start = 1'b0; dir_down = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) doEdge();
    checks++;
    if ({tick, running, expired, lap_active} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {tick, running, expired, lap_active});
    end
    checks++;
    if (disp !== 28'h0) begin
      failures++; $display("FAIL reset_display: got %h expected 0000000", disp);
    end
    rst = 1'b0;
    runCycles(5);
    checks++;
    if (running !== 1'b0 || tick !== 1'b0 || disp !== 28'h0) begin
      failures++; $display("FAIL idle_hold: running=%b tick=%b disp=%h expected 0 0 0000000", running, tick, disp);
    end
  endtask

  task automatic test_count_up();
    int badTick;
    pulseClear();
    pulseStart(1'b0);
    checks++;
    if (running !== 1'b1) begin
      failures++; $display("FAIL run_after_start: got %b expected 1", running);
    end
    badTick = 0;
    for (int c = 1; c <= 25; c++) begin
      doEdge();
      if (tick !== ((c == 10) || (c == 20))) badTick = c;
    end
    checks++;
    if (badTick != 0) begin
      failures++; $display("FAIL tick_timing: wrong tick at cycle %0d, expected ticks at 10 and 20", badTick);
    end
    checks++;
    if (disp !== 28'h0000002 || running !== 1'b1) begin
      failures++; $display("FAIL count_up_25: got %h running=%b expected 0000002 running=1", disp, running);
    end
  endtask

  task automatic test_wrap_up();
    pulseClear();
    preset_min = 8'h59; preset_sec = 8'h59; load = 1'b1; doEdge(); load = 1'b0;
    checks++;
    if (disp !== 28'h5959000) begin
      failures++; $display("FAIL load_5959: got %h expected 5959000", disp);
    end
    pulseStart(1'b0);
    runCycles(9990);
    checks++;
    if (disp !== 28'h5959999 || tickCnt != 999) begin
      failures++; $display("FAIL reach_5959999: got %h ticks=%0d expected 5959999 ticks=999", disp, tickCnt);
    end
    runCycles(10);
    checks++;
    if (disp !== 28'h0 || running !== 1'b1 || expCnt != 0 || tick !== 1'b1) begin
      failures++; $display("FAIL up_wrap: got %h running=%b expired_cnt=%0d tick=%b expected 0000000 1 0 1",
                           disp, running, expCnt, tick);
    end
  endtask

  task automatic test_countdown();
    pulseClear();
    preset_min = 8'h00; preset_sec = 8'h01; load = 1'b1; doEdge(); load = 1'b0;
    pulseStart(1'b1);
    runCycles(9999);
    checks++;
    if (disp !== 28'h0000001 || expCnt != 0 || running !== 1'b1) begin
      failures++; $display("FAIL down_near_zero: got %h expired_cnt=%0d running=%b expected 0000001 0 1",
                           disp, expCnt, running);
    end
    doEdge();
    checks++;
    if ({tick, expired, running} !== 3'b110 || disp !== 28'h0) begin
      failures++; $display("FAIL down_expire: tick/expired/running=%b disp=%h expected 110 0000000",
                           {tick, expired, running}, disp);
    end
    doEdge();
    checks++;
    if (expired !== 1'b0) begin
      failures++; $display("FAIL expire_single: got %b expected 0", expired);
    end
    tickCnt = 0; expCnt = 0;
    pulseStart(1'b0);
    lap = 1'b1; doEdge(); lap = 1'b0;
    runCycles(20);
    checks++;
    if (running !== 1'b0 || tickCnt != 0 || lap_active !== 1'b0 || disp !== 28'h0) begin
      failures++; $display("FAIL done_ignores: running=%b ticks=%0d lap=%b disp=%h expected 0 0 0 0000000",
                           running, tickCnt, lap_active, disp);
    end
  endtask

  task automatic test_pause_resume();
    int found;
    pulseClear();
    pulseStart(1'b0);
    runCycles(4);
    stop = 1'b1; doEdge(); stop = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      failures++; $display("FAIL pause_running: got %b expected 0", running);
    end
    runCycles(20);
    checks++;
    if (tickCnt != 0 || disp !== 28'h0) begin
      failures++; $display("FAIL pause_hold: ticks=%0d disp=%h expected 0 0000000", tickCnt, disp);
    end
    pulseStart(1'b0);
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      doEdge();
      if (tick) found = k;
    end
    checks++;
    if (found != 6) begin
      failures++; $display("FAIL resume_tick: tick after %0d cycles expected 6", found);
    end
    checks++;
    if (disp !== 28'h0000001) begin
      failures++; $display("FAIL resume_count: got %h expected 0000001", disp);
    end
  endtask

  task automatic test_lap();
    pulseClear();
    pulseStart(1'b0);
    runCycles(50);
    lap = 1'b1; doEdge(); lap = 1'b0;
    checks++;
    if (lap_active !== 1'b1 || ms_bcd !== 12'h005) begin
      failures++; $display("FAIL lap_set: lap=%b ms=%h expected 1 005", lap_active, ms_bcd);
    end
    runCycles(49);
    checks++;
    if (ms_bcd !== 12'h005 || lap_active !== 1'b1) begin
      failures++; $display("FAIL lap_frozen: ms=%h lap=%b expected 005 1", ms_bcd, lap_active);
    end
    lap = 1'b1; doEdge(); lap = 1'b0;
    checks++;
    if (lap_active !== 1'b0 || ms_bcd !== 12'h010) begin
      failures++; $display("FAIL lap_release: lap=%b ms=%h expected 0 010", lap_active, ms_bcd);
    end
    runCycles(9);
    checks++;
    if (ms_bcd !== 12'h011) begin
      failures++; $display("FAIL lap_live: ms=%h expected 011", ms_bcd);
    end
  endtask

  task automatic test_stop_clear();
    pulseClear();
    pulseStart(1'b0);
    runCycles(15);
    lap = 1'b1; doEdge(); lap = 1'b0;
    stop = 1'b1; clear = 1'b1; doEdge(); stop = 1'b0; clear = 1'b0;
    checks++;
    if (running !== 1'b0 || disp !== 28'h0 || lap_active !== 1'b0) begin
      failures++; $display("FAIL stop_clear: running=%b disp=%h lap=%b expected 0 0000000 0",
                           running, disp, lap_active);
    end
    tickCnt = 0;
    pulseStart(1'b0);
    runCycles(9);
    checks++;
    if (tickCnt != 0) begin
      failures++; $display("FAIL clear_prescaler_early: ticks=%0d expected 0", tickCnt);
    end
    runCycles(1);
    checks++;
    if (tickCnt != 1 || disp !== 28'h0000001) begin
      failures++; $display("FAIL clear_prescaler: ticks=%0d disp=%h expected 1 0000001", tickCnt, disp);
    end
  endtask

  task automatic test_zero_down();
    pulseClear();
    pulseStart(1'b1);
    checks++;
    if ({tick, expired, running} !== 3'b010) begin
      failures++; $display("FAIL zero_down_start: tick/expired/running=%b expected 010", {tick, expired, running});
    end
    doEdge();
    checks++;
    if (expired !== 1'b0 || tick !== 1'b0 || disp !== 28'h0) begin
      failures++; $display("FAIL zero_down_after: expired=%b tick=%b disp=%h expected 0 0 0000000",
                           expired, tick, disp);
    end
  endtask

  task automatic test_clamp_load();
    pulseClear();
    preset_min = 8'h7A; preset_sec = 8'h3C; load = 1'b1; doEdge(); load = 1'b0;
    checks++;
    if (disp !== 28'h5959000) begin
      failures++; $display("FAIL clamp: got %h expected 5959000", disp);
    end
    preset_min = 8'h42; preset_sec = 8'h07; load = 1'b1; doEdge(); load = 1'b0;
    checks++;
    if (disp !== 28'h4207000) begin
      failures++; $display("FAIL load_valid: got %h expected 4207000", disp);
    end
    preset_min = 8'h10; preset_sec = 8'h10; load = 1'b1; start = 1'b1; doEdge();
    load = 1'b0; start = 1'b0;
    checks++;
    if (running !== 1'b1 || disp !== 28'h4207000) begin
      failures++; $display("FAIL start_beats_load: running=%b disp=%h expected 1 4207000", running, disp);
    end
  endtask

  initial begin
    tickCnt = 0; expCnt = 0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_countdown();
    test_pause_resume();
    test_lap();
    test_stop_clear();
    test_zero_down();
    test_clamp_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
